// File: rtl/hdr_insert_pkg.sv
// Shared state encoding and default widths for the header-insertion sequencer.
package hdr_insert_pkg;

  localparam int DW_DEF = 64;
  localparam int AW_DEF = 6;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HDR     = 2'd2,
    PAYLOAD = 2'd3
  } state_e;

endpackage

// File: rtl/hdr_insert_ctrl_if.sv
// Payload-in / egress-out valid-ready streams of the header-insertion sequencer.
interface hdr_insert_ctrl_if
  import hdr_insert_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic [DW-1:0] pl_data;
  logic          pl_sop;
  logic          pl_eop;
  logic          pl_valid;
  logic          pl_ready;

  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_valid;
  logic          out_ready;

  // master: the environment feeding payload and sinking egress
  modport master (
    output pl_data, pl_sop, pl_eop, pl_valid,
    input  pl_ready,
    input  out_data, out_sop, out_eop, out_valid,
    output out_ready
  );

  // slave: the sequencer itself
  modport slave (
    input  pl_data, pl_sop, pl_eop, pl_valid,
    output pl_ready,
    output out_data, out_sop, out_eop, out_valid,
    input  out_ready
  );

endinterface

// File: rtl/hdr_rd_ptr.sv
// Header RAM read pointer: clear, increment, and last-word compare against the latched length.
module hdr_rd_ptr
  import hdr_insert_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [AW-1:0] len_i,
  output logic [AW-1:0] ptr_o,
  output logic [AW-1:0] ptr_nxt_o,
  output logic          last_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o     = ptr_q;
  assign ptr_nxt_o = ptr_q + AW'(1);
  assign last_o    = (ptr_q == len_i);

endmodule

// File: rtl/hdr_insert_ctrl.sv
// Prepends header words 0..len from the header RAM to each payload packet, then passes payload through.
module hdr_insert_ctrl
  import hdr_insert_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_mgmt,
  input  logic [AW-1:0]     hdr_len_mgmt,
  output logic              hdr_rd_en,
  output logic [AW-1:0]     hdr_rd_addr,
  input  logic [DW-1:0]     hdr_rd_data,
  hdr_insert_ctrl_if.slave  strm,
  output logic              busy,
  output logic              orphan_drop,
  output logic [CW-1:0]     pkt_cnt
);

  state_e        state_q, state_d;
  logic          en_q, en_d;
  logic [AW-1:0] len_q, len_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic          ptr_clr;
  logic          ptr_inc;
  logic          ptr_last;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;

  hdr_rd_ptr #(.AW(AW)) u_rd_ptr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (ptr_clr),
    .inc_i     (ptr_inc),
    .len_i     (len_q),
    .ptr_o     (ptr),
    .ptr_nxt_o (ptr_nxt),
    .last_o    (ptr_last)
  );

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    len_d         = len_q;
    pkt_cnt_d     = pkt_cnt_q;
    ptr_clr       = 1'b0;
    ptr_inc       = 1'b0;
    hdr_rd_en     = 1'b0;
    hdr_rd_addr   = '0;
    orphan_drop   = 1'b0;
    strm.pl_ready = 1'b0;
    strm.out_data = '0;
    strm.out_sop  = 1'b0;
    strm.out_eop  = 1'b0;
    strm.out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by rst so nothing is accepted or flagged while reset is held.
        if (strm.pl_valid && rst) begin
          if (strm.pl_sop) begin
            en_d    = enable_mgmt;
            len_d   = hdr_len_mgmt;
            state_d = enable_mgmt ? FETCH : PAYLOAD;
          end else begin
            strm.pl_ready = 1'b1;
            orphan_drop   = 1'b1;
          end
        end
      end

      FETCH: begin
        hdr_rd_en = 1'b1;
        ptr_clr   = 1'b1;
        state_d   = HDR;
      end

      HDR: begin
        strm.out_valid = 1'b1;
        strm.out_data  = hdr_rd_data;
        strm.out_sop   = (ptr == '0);
        // Read ahead only on an accepted beat; the RAM output holds otherwise.
        if (strm.out_ready) begin
          if (ptr_last) begin
            ptr_clr = 1'b1;
            state_d = PAYLOAD;
          end else begin
            hdr_rd_en   = 1'b1;
            hdr_rd_addr = ptr_nxt;
            ptr_inc     = 1'b1;
          end
        end
      end

      PAYLOAD: begin
        strm.out_data  = strm.pl_data;
        strm.out_valid = strm.pl_valid;
        strm.out_eop   = strm.pl_eop;
        strm.out_sop   = en_q ? 1'b0 : strm.pl_sop;
        strm.pl_ready  = strm.out_ready;
        if (strm.pl_valid && strm.out_ready && strm.pl_eop) begin
          state_d   = IDLE;
          pkt_cnt_d = pkt_cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      len_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      len_q     <= len_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_hdr_insert_ctrl.sv
// Directed self-checking bench for hdr_insert_ctrl with a registered header RAM model.
`timescale 1ns/1ps
module tb_hdr_insert_ctrl;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam logic [DW-1:0] HBASE = 64'hA5A5_0000_0000_0000;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable_mgmt;
  logic [AW-1:0] hdr_len_mgmt;
  logic          hdr_rd_en;
  logic [AW-1:0] hdr_rd_addr;
  logic [DW-1:0] hdr_rd_data = '0;
  logic          busy;
  logic          orphan_drop;
  logic [CW-1:0] pkt_cnt;

  hdr_insert_ctrl_if #(.DW(DW)) bus ();

  hdr_insert_ctrl #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_mgmt  (enable_mgmt),
    .hdr_len_mgmt (hdr_len_mgmt),
    .hdr_rd_en    (hdr_rd_en),
    .hdr_rd_addr  (hdr_rd_addr),
    .hdr_rd_data  (hdr_rd_data),
    .strm         (bus),
    .busy         (busy),
    .orphan_drop  (orphan_drop),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  // Header RAM: word i holds HBASE+i, one-cycle registered read that holds when idle
  logic [DW-1:0] hram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) hram[i] = HBASE + DW'(i);
  always @(posedge clk) if (hdr_rd_en) hdr_rd_data <= hram[hdr_rd_addr];

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    start_cyc;
  int    orphan_cnt;
  int    stall_reads;
  bit    toggle_mode = 1'b0;
  beat_t eg_q[$];
  int    eg_cyc[$];
  int    addr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are decided at mid-cycle: inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        eg_q.push_back({bus.out_sop, bus.out_eop, bus.out_data});
        eg_cyc.push_back(cyc);
      end
      if (hdr_rd_en) addr_q.push_back(int'(hdr_rd_addr));
      if (hdr_rd_en && bus.out_valid && !bus.out_ready) stall_reads++;
      if (orphan_drop) orphan_cnt++;
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = toggle_mode ? ~bus.out_ready : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    eg_q.delete();
    eg_cyc.delete();
    addr_q.delete();
    stall_reads = 0;
    orphan_cnt  = 0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [DW-1:0] base);
    int   guard;
    logic acc;
    start_cyc = cyc;
    for (int b = 0; b < nbeats; b++) begin
      bus.pl_valid = 1'b1;
      bus.pl_data  = base + DW'(b);
      bus.pl_sop   = (b == 0);
      bus.pl_eop   = (b == nbeats - 1);
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = bus.pl_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 500) begin
          check("pl_handshake_timeout", 128'(guard), 128'(0));
          break;
        end
      end
    end
    bus.pl_valid = 1'b0;
    bus.pl_sop   = 1'b0;
    bus.pl_eop   = 1'b0;
  endtask

  task automatic check_egress(input string tag, input int nh, input int np, input bit ins,
                              input logic [DW-1:0] pbase);
    beat_t exp;
    check({tag, "_nbeats"}, 128'(eg_q.size()), 128'(nh + np));
    for (int i = 0; i < nh + np && i < eg_q.size(); i++) begin
      if (i < nh) exp = {1'(i == 0), 1'b0, HBASE + DW'(i)};
      else        exp = {1'(!ins && i == 0), 1'(i == nh + np - 1), pbase + DW'(i - nh)};
      check($sformatf("%s_beat%0d", tag, i), 128'(eg_q[i]), 128'(exp));
    end
  endtask

  task automatic check_addrs(input string tag, input int n);
    check({tag, "_nreads"}, 128'(addr_q.size()), 128'(n));
    for (int i = 0; i < n && i < addr_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 128'(addr_q[i]), 128'(i));
  endtask

  task automatic report(input string tag);
    $display("txn %s: %0d egress beats, %0d header reads, pkt_cnt=%0d", tag, eg_q.size(),
             addr_q.size(), pkt_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable_mgmt  = 1'b0;
    hdr_len_mgmt = '0;
    bus.pl_valid = 1'b0;
    bus.pl_sop   = 1'b0;
    bus.pl_eop   = 1'b0;
    bus.pl_data  = '0;
    clear_logs();
    tick(3);

    check("rst_out_valid",   128'(bus.out_valid), 128'(0));
    check("rst_pl_ready",    128'(bus.pl_ready),  128'(0));
    check("rst_hdr_rd_en",   128'(hdr_rd_en),     128'(0));
    check("rst_hdr_rd_addr", 128'(hdr_rd_addr),   128'(0));
    check("rst_busy",        128'(busy),          128'(0));
    check("rst_pkt_cnt",     128'(pkt_cnt),       128'(0));
    rst = 1'b1;
    tick(2);

    // len=2 insert, 3-beat payload, full ready
    enable_mgmt  = 1'b1;
    hdr_len_mgmt = 6'd2;
    clear_logs();
    send_pkt(3, 64'h1111_0000_0000_0000);
    tick(3);
    report("t1");
    check_egress("t1", 3, 3, 1'b1, 64'h1111_0000_0000_0000);
    check_addrs("t1", 3);
    if (eg_cyc.size() == 6) begin
      check("t1_first_hdr_latency", 128'(eg_cyc[0] - start_cyc), 128'(2));
      check("t1_sop_to_eop",        128'(eg_cyc[5] - start_cyc), 128'(7));
    end
    check("t1_pkt_cnt", 128'(pkt_cnt), 128'(1));
    check("t1_busy",    128'(busy),    128'(0));

    // same packet with out_ready toggling
    toggle_mode = 1'b1;
    tick(1);
    clear_logs();
    send_pkt(3, 64'h1111_0000_0000_0000);
    toggle_mode = 1'b0;
    tick(4);
    report("t2");
    check_egress("t2", 3, 3, 1'b1, 64'h1111_0000_0000_0000);
    check_addrs("t2", 3);
    check("t2_stall_reads", 128'(stall_reads), 128'(0));
    check("t2_pkt_cnt",     128'(pkt_cnt),     128'(2));

    // bypass, 2-beat payload
    enable_mgmt  = 1'b0;
    hdr_len_mgmt = 6'd5;
    clear_logs();
    send_pkt(2, 64'h2222_0000_0000_0000);
    tick(3);
    report("t3");
    check_egress("t3", 0, 2, 1'b0, 64'h2222_0000_0000_0000);
    check("t3_nreads",  128'(addr_q.size()), 128'(0));
    check("t3_pkt_cnt", 128'(pkt_cnt),       128'(3));

    // len=0 with single-beat sop+eop payload
    enable_mgmt  = 1'b1;
    hdr_len_mgmt = 6'd0;
    clear_logs();
    send_pkt(1, 64'h3333_0000_0000_0000);
    tick(3);
    report("t4");
    check_egress("t4", 1, 1, 1'b1, 64'h3333_0000_0000_0000);
    check_addrs("t4", 1);
    check("t4_busy",    128'(busy),    128'(0));
    check("t4_pkt_cnt", 128'(pkt_cnt), 128'(4));

    // orphan beat in IDLE
    clear_logs();
    bus.pl_valid = 1'b1;
    bus.pl_sop   = 1'b0;
    bus.pl_eop   = 1'b1;
    bus.pl_data  = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    check("t5_orphan_pl_ready", 128'(bus.pl_ready), 128'(1));
    check("t5_orphan_pulse",    128'(orphan_drop),  128'(1));
    tick(1);
    bus.pl_valid = 1'b0;
    bus.pl_eop   = 1'b0;
    @(negedge clk);
    check("t5_orphan_pulse_end", 128'(orphan_drop), 128'(0));
    tick(3);
    report("t5");
    check("t5_egress",     128'(eg_q.size()), 128'(0));
    check("t5_orphan_cnt", 128'(orphan_cnt),  128'(1));
    check("t5_busy",       128'(busy),        128'(0));
    check("t5_pkt_cnt",    128'(pkt_cnt),     128'(4));

    // reset asserted while in HDR with ptr=3
    hdr_len_mgmt = 6'd5;
    clear_logs();
    bus.pl_valid = 1'b1;
    bus.pl_sop   = 1'b1;
    bus.pl_eop   = 1'b0;
    bus.pl_data  = 64'h4444_0000_0000_0000;
    tick(5);
    check("t6_hdr3_data", 128'(bus.out_data), 128'(HBASE + 64'd3));
    check("t6_hdr3_addr", 128'(hdr_rd_addr),  128'(4));
    rst = 1'b0;
    #1;
    check("t6_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("t6_rst_out_data",  128'(bus.out_data),  128'(0));
    check("t6_rst_rd_en",     128'(hdr_rd_en),     128'(0));
    check("t6_rst_rd_addr",   128'(hdr_rd_addr),   128'(0));
    check("t6_rst_busy",      128'(busy),          128'(0));
    check("t6_rst_pkt_cnt",   128'(pkt_cnt),       128'(0));
    bus.pl_valid = 1'b0;
    bus.pl_sop   = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    hdr_len_mgmt = 6'd1;
    clear_logs();
    send_pkt(1, 64'h5555_0000_0000_0000);
    tick(3);
    report("t6");
    check_egress("t6", 2, 1, 1'b1, 64'h5555_0000_0000_0000);
    check_addrs("t6", 2);
    check("t6_pkt_cnt", 128'(pkt_cnt), 128'(1));

    // full 64-word header; management changes mid-packet are ignored
    enable_mgmt  = 1'b1;
    hdr_len_mgmt = 6'd63;
    clear_logs();
    fork
      send_pkt(2, 64'h6666_0000_0000_0000);
      begin
        tick(10);
        hdr_len_mgmt = 6'd2;
        enable_mgmt  = 1'b0;
      end
    join
    tick(3);
    report("t7");
    check_egress("t7", 64, 2, 1'b1, 64'h6666_0000_0000_0000);
    check_addrs("t7", 64);
    check("t7_pkt_cnt", 128'(pkt_cnt), 128'(2));
    check("t7_busy",    128'(busy),    128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
